// File: rtl/vita49_pkg.sv
// Shared constants, FSM state type and header helpers for the VITA-49 IF Data packetiser.
package vita49_pkg;

    localparam int          C_HDR_WORDS    = 5;
    localparam logic [15:0] C_MAX_PAYLOAD  = 16'd65530;
    localparam logic [3:0]  C_PKT_TYPE     = 4'b0001;
    localparam logic [1:0]  C_TSI_UTC      = 2'b01;
    localparam logic [1:0]  C_TSF_REALTIME = 2'b10;

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    function automatic logic [31:0] build_hdr(input logic [3:0] pkt_cnt, input logic [15:0] size);
        return {C_PKT_TYPE, 4'b0000, C_TSI_UTC, C_TSF_REALTIME, pkt_cnt, size};
    endfunction

    // Zero-length packets become one word; the cap keeps len+5 inside the 16-bit size field.
    function automatic logic [15:0] clamp_len(input logic [15:0] words);
        if (words == 16'd0)
            return 16'd1;
        else if (words > C_MAX_PAYLOAD)
            return C_MAX_PAYLOAD;
        else
            return words;
    endfunction

endpackage

// File: rtl/vita49_pack_logic.sv
// Frames gated 32-bit samples into fixed-length VITA-49 IF Data packets:
// five prologue words followed by a zero-latency payload passthrough.
//   state | meaning
//   IDLE  | waiting for enable and a pending sample
//   HDR   | emitting prologue words 0..4, input stalled
//   PAY   | passing payload words through until len words are sent
module vita49_pack_logic
    import vita49_pkg::*;
#(
    parameter int C_AXIS_TDATA_NUM_BYTES = 4
) (
    input  logic        AXIS_ACLK,
    input  logic        AXIS_ARESETN,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic [3:0]  S_AXIS_TSTRB,
    input  logic        S_AXIS_TLAST,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic [3:0]  M_AXIS_TSTRB,
    output logic        M_AXIS_TLAST,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    input  logic [31:0] ctrl,
    output logic [31:0] status,
    input  logic [31:0] stream_id,
    input  logic [15:0] pkt_words,
    input  logic [31:0] tsi,
    input  logic [63:0] tsf
);

    generate
        if (C_AXIS_TDATA_NUM_BYTES != 4) begin : g_bad_width
            $error("vita49_pack_logic supports only 4-byte streams");
        end
    endgenerate

    localparam logic [2:0] HDR_LAST = 3'(C_HDR_WORDS - 1);

    logic [1:0]  ctrl_reg;
    logic [31:0] stream_id_reg, tsi_reg;
    logic [15:0] pkt_words_reg;
    logic [63:0] tsf_reg;

    state_t      state, state_nxt;
    logic [2:0]  idx;
    logic [15:0] cnt, len;
    logic [31:0] sid, ts_i;
    logic [63:0] ts_f;
    logic [3:0]  pkt_cnt;
    logic [15:0] sent_cnt;

    logic en, soft_rst, rst_eff, m_hs, pay_last;
    logic unused_inputs;

    assign en       = ctrl_reg[0];
    assign soft_rst = ctrl_reg[1];
    assign rst_eff  = !AXIS_ARESETN || soft_rst;
    assign m_hs     = M_AXIS_TVALID && M_AXIS_TREADY;
    assign pay_last = (cnt == len - 16'd1);
    assign status   = {sent_cnt, 11'd0, (state != IDLE), pkt_cnt};
    assign unused_inputs = ^{S_AXIS_TLAST, ctrl[31:2]};

    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            ctrl_reg      <= '0;
            stream_id_reg <= '0;
            pkt_words_reg <= '0;
            tsi_reg       <= '0;
            tsf_reg       <= '0;
        end else begin
            ctrl_reg      <= ctrl[1:0];
            stream_id_reg <= stream_id;
            pkt_words_reg <= pkt_words;
            tsi_reg       <= tsi;
            tsf_reg       <= tsf;
        end
    end

    always_comb begin
        state_nxt     = state;
        M_AXIS_TDATA  = '0;
        M_AXIS_TSTRB  = '0;
        M_AXIS_TLAST  = 1'b0;
        M_AXIS_TVALID = 1'b0;
        S_AXIS_TREADY = 1'b0;
        // Outputs stay quiet while a soft reset is pending so nothing leaks mid-abort.
        if (!soft_rst) begin
            case (state)
                IDLE: begin
                    if (en && S_AXIS_TVALID)
                        state_nxt = HDR;
                end
                HDR: begin
                    M_AXIS_TVALID = 1'b1;
                    M_AXIS_TSTRB  = 4'hF;
                    case (idx)
                        3'd0:    M_AXIS_TDATA = build_hdr(pkt_cnt, len + 16'(C_HDR_WORDS));
                        3'd1:    M_AXIS_TDATA = sid;
                        3'd2:    M_AXIS_TDATA = ts_i;
                        3'd3:    M_AXIS_TDATA = ts_f[63:32];
                        3'd4:    M_AXIS_TDATA = ts_f[31:0];
                        default: M_AXIS_TDATA = '0;
                    endcase
                    if (M_AXIS_TREADY && idx == HDR_LAST)
                        state_nxt = PAY;
                end
                PAY: begin
                    M_AXIS_TDATA  = S_AXIS_TDATA;
                    M_AXIS_TSTRB  = S_AXIS_TSTRB;
                    M_AXIS_TVALID = S_AXIS_TVALID;
                    M_AXIS_TLAST  = pay_last;
                    S_AXIS_TREADY = M_AXIS_TREADY;
                    if (S_AXIS_TVALID && M_AXIS_TREADY && pay_last)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (rst_eff) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            len      <= 16'd1;
            sid      <= '0;
            ts_i     <= '0;
            ts_f     <= '0;
            pkt_cnt  <= '0;
            sent_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (state_nxt == HDR) begin
                        ts_i <= tsi_reg;
                        ts_f <= tsf_reg;
                        sid  <= stream_id_reg;
                        len  <= clamp_len(pkt_words_reg);
                        idx  <= '0;
                    end
                end
                HDR: begin
                    if (m_hs) begin
                        if (idx == HDR_LAST)
                            cnt <= '0;
                        else
                            idx <= idx + 3'd1;
                    end
                end
                PAY: begin
                    if (m_hs) begin
                        if (pay_last) begin
                            pkt_cnt  <= pkt_cnt + 4'd1;
                            sent_cnt <= sent_cnt + 16'd1;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vita49_pack_logic.sv
// Self-checking bench: expected packet words come from a queue model built from the framing rules.
module tb_vita49_pack_logic;

    logic        AXIS_ACLK = 1'b0;
    logic        AXIS_ARESETN;
    logic [31:0] S_AXIS_TDATA;
    logic [3:0]  S_AXIS_TSTRB;
    logic        S_AXIS_TLAST;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TREADY;
    logic [31:0] M_AXIS_TDATA;
    logic [3:0]  M_AXIS_TSTRB;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic [31:0] ctrl;
    logic [31:0] status;
    logic [31:0] stream_id;
    logic [15:0] pkt_words;
    logic [31:0] tsi;
    logic [63:0] tsf;

    vita49_pack_logic #(.C_AXIS_TDATA_NUM_BYTES(4)) dut (
        .AXIS_ACLK(AXIS_ACLK), .AXIS_ARESETN(AXIS_ARESETN),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TLAST(S_AXIS_TLAST),
        .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
        .ctrl(ctrl), .status(status), .stream_id(stream_id), .pkt_words(pkt_words),
        .tsi(tsi), .tsf(tsf)
    );

    always #5 AXIS_ACLK = ~AXIS_ACLK;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
        logic        h;
    } beat_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
    } smp_t;

    beat_t exp_q[$];
    smp_t  src[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   mpc = 0;
    int   msent = 0;
    int   rdy_mode = 0;
    bit   vld_rand = 0;
    bit   s_pend = 0;
    logic held_v = 1'b0;
    logic [31:0] held_d;
    logic m_hs, s_hs;
    int   beats = 0;
    int   pay_beats = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, observe 1 ns later, score what the next rising edge will transfer.
    task automatic step();
        @(negedge AXIS_ACLK);
        case (rdy_mode)
            0:       M_AXIS_TREADY = 1'b1;
            1:       M_AXIS_TREADY = ~M_AXIS_TREADY;
            default: M_AXIS_TREADY = 1'($urandom_range(0, 1));
        endcase
        if (src.size() > 0) begin
            if (!s_pend)
                S_AXIS_TVALID = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            S_AXIS_TDATA = src[0].d;
            S_AXIS_TSTRB = src[0].s;
        end else begin
            S_AXIS_TVALID = 1'b0;
        end
        #1;
        if (held_v) begin
            chk("hold_valid", M_AXIS_TVALID, 1);
            chk("hold_data", M_AXIS_TDATA, held_d);
        end
        m_hs = M_AXIS_TVALID && M_AXIS_TREADY;
        s_hs = S_AXIS_TVALID && S_AXIS_TREADY;
        if (M_AXIS_TVALID && exp_q.size() > 0 && exp_q[0].h)
            chk("hdr_sready", S_AXIS_TREADY, 0);
        if (s_hs)
            chk("pay_pair", m_hs, 1);
        if (m_hs) begin
            chk("beat_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                chk("beat_data", M_AXIS_TDATA, exp_q[0].d);
                chk("beat_strb", M_AXIS_TSTRB, exp_q[0].s);
                chk("beat_last", M_AXIS_TLAST, exp_q[0].l);
                if (!exp_q[0].h) pay_beats++;
                void'(exp_q.pop_front());
            end
            beats++;
        end
        if (s_hs) void'(src.pop_front());
        s_pend = S_AXIS_TVALID && !s_hs;
        held_v = M_AXIS_TVALID && !M_AXIS_TREADY;
        held_d = M_AXIS_TDATA;
    endtask

    task automatic push_beat(input logic [31:0] d, input logic [3:0] s, input logic l, input logic h);
        beat_t b;
        b.d = d; b.s = s; b.l = l; b.h = h;
        exp_q.push_back(b);
    endtask

    task automatic queue_hdr(input int eff);
        logic [3:0]  pc;
        logic [15:0] size;
        pc   = mpc[3:0];
        size = 16'(eff + 5);
        push_beat({4'b0001, 4'b0000, 2'b01, 2'b10, pc, size}, 4'hF, 1'b0, 1'b1);
        push_beat(stream_id, 4'hF, 1'b0, 1'b1);
        push_beat(tsi, 4'hF, 1'b0, 1'b1);
        push_beat(tsf[63:32], 4'hF, 1'b0, 1'b1);
        push_beat(tsf[31:0], 4'hF, 1'b0, 1'b1);
    endtask

    task automatic queue_pkt(input bit seq);
        int   eff;
        smp_t sm;
        eff = (pkt_words == 16'd0) ? 1 : (int'(pkt_words) > 65530 ? 65530 : int'(pkt_words));
        queue_hdr(eff);
        for (int i = 0; i < eff; i++) begin
            sm.d = seq ? 32'(i + 1) : $urandom;
            sm.s = seq ? 4'hF : 4'($urandom_range(0, 15));
            src.push_back(sm);
            push_beat(sm.d, sm.s, i == eff - 1, 1'b0);
        end
        mpc   = (mpc + 1) % 16;
        msent = (msent + 1) % 65536;
    endtask

    task automatic drain();
        for (int k = 0; k < 3000 && exp_q.size() > 0; k++) step();
        chk("drain_left", exp_q.size(), 0);
        step();
    endtask

    task automatic check_status();
        chk("st_pkt_cnt", status[3:0], mpc[3:0]);
        chk("st_busy", status[4], 0);
        chk("st_sent", status[31:16], msent[15:0]);
    endtask

    initial begin
        int b0;
        int p0;
        AXIS_ARESETN = 1'b0;
        ctrl = '0; stream_id = '0; pkt_words = '0; tsi = '0; tsf = '0;
        S_AXIS_TDATA = '0; S_AXIS_TSTRB = '0; S_AXIS_TLAST = 1'b0; S_AXIS_TVALID = 1'b0;
        M_AXIS_TREADY = 1'b1;
        repeat (3) @(negedge AXIS_ACLK);
        AXIS_ARESETN = 1'b1;
        #1;
        chk("rst_mvalid", M_AXIS_TVALID, 0);
        chk("rst_sready", S_AXIS_TREADY, 0);
        chk("rst_mlast", M_AXIS_TLAST, 0);
        chk("rst_status", status, 0);

        // basic packet
        ctrl = 32'h1; pkt_words = 16'd4; stream_id = 32'hCAFE0001; tsi = 32'd100; tsf = 64'h200;
        step(); step();
        b0 = beats;
        queue_pkt(1);
        drain();
        chk("basic_beats", beats - b0, 9);
        check_status();

        // backpressure toggling every cycle
        rdy_mode = 1;
        b0 = beats;
        queue_pkt(1);
        drain();
        chk("bp_beats", beats - b0, 9);
        check_status();

        // randomized packets, fields and handshakes
        rdy_mode = 2; vld_rand = 1;
        for (int n = 0; n < 6; n++) begin
            pkt_words = 16'($urandom_range(1, 8));
            stream_id = $urandom; tsi = $urandom; tsf = {$urandom, $urandom};
            step();
            queue_pkt(0);
            drain();
            check_status();
        end

        // upper clamp: header only, then abort with soft reset
        rdy_mode = 0; vld_rand = 0;
        pkt_words = 16'hFFFF;
        step(); step();
        queue_hdr(65530);
        for (int i = 0; i < 2; i++) begin
            smp_t sm;
            sm.d = $urandom; sm.s = 4'hF;
            src.push_back(sm);
            push_beat(sm.d, sm.s, 1'b0, 1'b0);
        end
        drain();
        chk("ffff_busy", status[4], 1);
        ctrl = 32'h2; pkt_words = 16'd1;
        step(); step();
        ctrl = 32'h1;
        step();
        mpc = 0; msent = 0;
        check_status();

        // counter wrap: 17 back-to-back single-word packets
        pkt_words = 16'd1;
        step(); step();
        for (int n = 0; n < 17; n++) queue_pkt(0);
        drain();
        check_status();

        // lower clamp
        pkt_words = 16'd0;
        step(); step();
        queue_pkt(0);
        drain();
        check_status();

        // enable dropped after two payload words
        pkt_words = 16'd4;
        step(); step();
        queue_pkt(0);
        for (int i = 0; i < 2; i++) begin
            smp_t sm;
            sm.d = $urandom; sm.s = 4'hF;
            src.push_back(sm);
        end
        p0 = pay_beats;
        for (int k = 0; k < 200 && pay_beats - p0 < 2; k++) step();
        chk("dis_reached", pay_beats - p0, 2);
        ctrl = 32'h0;
        repeat (12) step();
        chk("dis_left", exp_q.size(), 0);
        chk("dis_src_left", src.size(), 2);
        check_status();
        src.delete();
        s_pend = 0;
        step();

        // hard reset during header word 2
        ctrl = 32'h1; pkt_words = 16'd3; tsi = 32'h1111; tsf = 64'h2222_0000_3333;
        step(); step();
        queue_pkt(0);
        b0 = beats;
        for (int k = 0; k < 200 && beats - b0 < 2; k++) step();
        chk("rst_reached", beats - b0, 2);
        @(negedge AXIS_ACLK);
        AXIS_ARESETN = 1'b0;
        @(negedge AXIS_ACLK);
        AXIS_ARESETN = 1'b1;
        tsi = 32'h5555; tsf = 64'h6666_7777_8888;
        #1;
        chk("mid_rst_mvalid", M_AXIS_TVALID, 0);
        chk("mid_rst_busy", status[4], 0);
        chk("mid_rst_pkt_cnt", status[3:0], 0);
        exp_q.delete();
        held_v = 1'b0;
        mpc = 0; msent = 0;
        queue_hdr(3);
        for (int i = 0; i < src.size(); i++)
            push_beat(src[i].d, src[i].s, i == src.size() - 1, 1'b0);
        mpc = 1; msent = 1;
        drain();
        check_status();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
